// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, encodings and helpers for the load/store initiator
// Contents: funct3 encodings, FSM state enum, XLEN/MEM_AW defaults,
//           access-error decode helper.
package lsu_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int MEM_AW_DEF = 6;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP,
        ST_ERR
    } lsu_state_t;

    // Illegal funct3 or misaligned address for the requested access size.
    // Unsigned variants exist only for loads.
    function automatic logic lsu_access_err(input logic       write,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = addr_lo[0];
            F3_W:    err = (addr_lo != 2'b00);
            F3_BU:   err = write;
            F3_HU:   err = write | addr_lo[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational load extract/extend and store lane merge
// Ports:
//   i_funct3     access size / signedness
//   i_addr_lo    byte offset within the word
//   i_rdata      memory word as read
//   i_wdata      right-aligned store data
//   o_load_data  selected lane, sign- or zero-extended
//   o_merge_data memory word with the addressed lane replaced by store data
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_rdata,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_load_data,
    output logic [XLEN-1:0] o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_load_data = i_rdata;
        case (i_funct3)
            F3_B:    o_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_H:    o_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   o_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_load_data = i_rdata;
        endcase

        o_merge_data = i_rdata;
        case (i_funct3)
            F3_B: begin
                case (i_addr_lo)
                    2'd0: o_merge_data[7:0]   = i_wdata[7:0];
                    2'd1: o_merge_data[15:8]  = i_wdata[7:0];
                    2'd2: o_merge_data[23:16] = i_wdata[7:0];
                    2'd3: o_merge_data[31:24] = i_wdata[7:0];
                    default: o_merge_data = i_rdata;
                endcase
            end
            F3_H: begin
                if (i_addr_lo[1])
                    o_merge_data[31:16] = i_wdata[15:0];
                else
                    o_merge_data[15:0]  = i_wdata[15:0];
            end
            default: o_merge_data = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator to word-addressed data memory
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_write/req_funct3     store flag and RV32 funct3
//   req_addr/req_wdata       byte address and right-aligned store data
//   resp_valid/resp_rdata/resp_err  one-cycle completion with load data / error
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata  memory pins
// Build option: LSU_RANGE_CHK_EN makes nonzero address bits above the
// memory window an access error instead of aliasing.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEF,
    parameter int XLEN   = XLEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    lsu_state_t        r_state;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic [XLEN-1:0]   r_wdata;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [XLEN-1:0]   r_resp_rdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [XLEN-1:0]   r_mem_wdata;   // doubles as the read-modify-write merge register

    logic              w_range_err;
    logic              w_err;
    logic [XLEN-1:0]   w_load_data;
    logic [XLEN-1:0]   w_merge_data;

`ifdef LSU_RANGE_CHK_EN
    assign w_range_err = |req_addr[XLEN-1:MEM_AW+2];
`else
    logic w_unused_upper_addr;
    assign w_unused_upper_addr = |req_addr[XLEN-1:MEM_AW+2];
    assign w_range_err = 1'b0;
`endif

    assign w_err = lsu_access_err(req_write, req_funct3, req_addr[1:0]) | w_range_err;

    lsu_lane_align #(.XLEN(XLEN)) u_lane_align (
        .i_funct3     (r_funct3),
        .i_addr_lo    (r_addr_lo),
        .i_rdata      (mem_rdata),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // Outputs are registered on the transition into the state that owns them,
    // so each strobe is high exactly for the duration of that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_funct3     <= 3'd0;
            r_addr_lo    <= 2'd0;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_req_ready  <= 1'b0;
                        r_funct3     <= req_funct3;
                        r_addr_lo    <= req_addr[1:0];
                        r_wdata      <= req_wdata;
                        r_mem_addr   <= req_addr[MEM_AW+1:2];
                        r_resp_rdata <= '0;
                        if (w_err) begin
                            r_state      <= ST_ERR;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (!req_write) begin
                            r_state    <= ST_LOAD;
                            r_mem_read <= 1'b1;
                        end else if (req_funct3 == F3_W) begin
                            r_state     <= ST_WRITE;
                            r_mem_write <= 1'b1;
                            r_mem_wdata <= req_wdata;
                        end else begin
                            r_state    <= ST_RMW_RD;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    r_resp_rdata <= w_load_data;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RMW_RD: begin
                    r_mem_wdata <= w_merge_data;
                    r_mem_write <= 1'b1;
                    r_state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP, ST_ERR: begin
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - self-checking bench for lsu_mem_master
module tb_lsu_mem_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic        mem_load;

    int n_checks;
    int n_err;
    int resp_cnt;
    int overlap_cnt;

    lsu_mem_master #(.MEM_AW(6), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_read ? mem[mem_addr] : 32'h0;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h0000_0011;
            mem[1] <= 32'h0000_0009;
            mem[2] <= 32'h0000_0019;
            mem[5] <= 32'h0102_0304;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (resp_valid) resp_cnt++;
        if (mem_read && mem_write) overlap_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic        exp_rd;
        logic        exp_wr;
        logic        chk_mem;
        int          midx;
        logic [31:0] mval;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input int lat, input logic err,
                                input logic [31:0] rd, input logic erd, input logic ewr,
                                input logic cm, input int mi, input logic [31:0] mv);
        vec_t v;
        v.write = w; v.f3 = f3; v.addr = a; v.wdata = wd; v.lat = lat; v.err = err;
        v.rdata = rd; v.exp_rd = erd; v.exp_wr = ewr; v.chk_mem = cm; v.midx = mi; v.mval = mv;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        int   pulses;
        logic got_err;
        logic [31:0] got_rd;
        logic saw_rd;
        logic saw_wr;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_write  = v.write;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; pulses = 0; got_err = 1'b0; got_rd = 32'h0; saw_rd = 1'b0; saw_wr = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (mem_read)  saw_rd = 1'b1;
            if (mem_write) saw_wr = 1'b1;
            if (resp_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat    = k;
                    got_err = resp_err;
                    got_rd  = resp_rdata;
                end
            end
        end
        check({tag, ".latency"}, lat, v.lat);
        check({tag, ".pulses"}, pulses, 1);
        check({tag, ".err"}, {31'h0, got_err}, {31'h0, v.err});
        check({tag, ".rdata"}, got_rd, v.rdata);
        check({tag, ".mem_read_seen"}, {31'h0, saw_rd}, {31'h0, v.exp_rd});
        check({tag, ".mem_write_seen"}, {31'h0, saw_wr}, {31'h0, v.exp_wr});
        if (v.chk_mem) check({tag, ".mem_word"}, mem[v.midx], v.mval);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   low_cnt;
        int   resp_before;
        logic alias_err;
        logic [31:0] alias_rd;
        n_checks = 0; n_err = 0; resp_cnt = 0; overlap_cnt = 0;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        mem_load = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.req_ready",  {31'h0, req_ready},  32'h1);
        check("reset.resp_valid", {31'h0, resp_valid}, 32'h0);
        check("reset.resp_err",   {31'h0, resp_err},   32'h0);
        check("reset.resp_rdata", resp_rdata, 32'h0);
        check("reset.mem_rw",     {30'h0, mem_read, mem_write}, 32'h0);
        check("reset.mem_addr",   {26'h0, mem_addr}, 32'h0);
        check("reset.mem_wdata",  mem_wdata, 32'h0);
        mem_load = 1'b0;
        rst = 1'b0;

`ifdef LSU_RANGE_CHK_EN
        alias_err = 1'b1; alias_rd = 32'h0;
`else
        alias_err = 1'b0; alias_rd = 32'h0000_0019;
`endif

        //                w  f3    addr          wdata         lat err rdata         rd wr cm idx mval
        vecs.push_back(mk(0, 3'd2, 32'h0000_0008, 32'h0,        2, 0, 32'h0000_0019, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'd0, 32'h0000_0005, 32'h0000_00AB, 3, 0, 32'h0,        1, 1, 1, 1, 32'h0000_AB09));
        vecs.push_back(mk(0, 3'd4, 32'h0000_0005, 32'h0,        2, 0, 32'h0000_00AB, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'd0, 32'h0000_0005, 32'h0,        2, 0, 32'hFFFF_FFAB, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'd1, 32'h0000_0002, 32'h0000_8001, 3, 0, 32'h0,        1, 1, 1, 0, 32'h8001_0011));
        vecs.push_back(mk(0, 3'd1, 32'h0000_0002, 32'h0,        2, 0, 32'hFFFF_8001, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'd5, 32'h0000_0002, 32'h0,        2, 0, 32'h0000_8001, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'd2, 32'h0000_0000, 32'h0,        2, 0, 32'h8001_0011, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'd2, 32'h0000_0006, 32'h0,        1, 1, 32'h0,        0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'd1, 32'h0000_0003, 32'h0,        1, 1, 32'h0,        0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'd3, 32'h0000_0000, 32'h0,        1, 1, 32'h0,        0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'd4, 32'h0000_0004, 32'h0000_0077, 1, 1, 32'h0,        0, 0, 1, 1, 32'h0000_AB09));
        vecs.push_back(mk(1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 2, 0, 32'h0,        0, 1, 1, 4, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 3'd1, 32'h0000_0012, 32'h0,        2, 0, 32'hFFFF_DEAD, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'd0, 32'h0000_0013, 32'h0,        2, 0, 32'hFFFF_FFDE, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'd4, 32'h0000_0010, 32'h0,        2, 0, 32'h0000_00EF, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'd2, 32'h0000_0108, 32'h0,        alias_err ? 1 : 2, alias_err, alias_rd,
                          !alias_err, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Back-to-back SW with req_valid held high throughout.
        @(negedge clk);
        resp_before = resp_cnt;
        check("b2b.ready_first", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h0000_0020; req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1 req_addr = 32'h0000_0024; req_wdata = 32'hCAFE_F00D;
        low_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready) break;
            low_cnt++;
        end
        check("b2b.ready_low_cycles", low_cnt, 2);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("b2b.resp_pulses", resp_cnt - resp_before, 2);
        check("b2b.word8", mem[8], 32'h1234_5678);
        check("b2b.word9", mem[9], 32'hCAFE_F00D);

        // Reset while an SB sits in WRITE.
        @(negedge clk);
        resp_before = resp_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'h0000_0014; req_wdata = 32'h0000_005A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 check("rstmid.in_write", {31'h0, mem_write}, 32'h1);
        rst = 1'b1;
        #1 check("rstmid.write_drop", {31'h0, mem_write}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rstmid.word5", mem[5], 32'h0102_0304);
        check("rstmid.ready", {31'h0, req_ready}, 32'h1);
        repeat (3) @(negedge clk);
        check("rstmid.no_resp", resp_cnt - resp_before, 0);

        check("rw_overlap", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
